// File: rtl/ar_lane_collect4_pkg.sv
// ar_lane_collect4_pkg: shared lane count, select width, default word width and counter-width helper
package ar_lane_collect4_pkg;
  localparam int LANES = 4;
  localparam int SEL_W = 2;
  localparam int WORD_W_DEF = 8;
  typedef logic [SEL_W-1:0] lane_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/ar_lane_collect4_if.sv
// ar_lane_collect4_if: demux sample input plus valid/ready word output port
// in_valid/in_sel/in_y: demux enable, select and 4-bit lane vector
// out_valid/out_ready/out_lane/out_data: arbitrated word handshake; ovf: sticky per-lane overflow
interface ar_lane_collect4_if
  import ar_lane_collect4_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
);
  logic in_valid;
  lane_t in_sel;
  logic [LANES-1:0] in_y;
  logic out_valid;
  logic out_ready;
  lane_t out_lane;
  logic [WORD_W-1:0] out_data;
  logic [LANES-1:0] ovf;
  modport master (
    output in_valid, in_sel, in_y, out_ready,
    input out_valid, out_lane, out_data, ovf
  );
  modport slave (
    input in_valid, in_sel, in_y, out_ready,
    output out_valid, out_lane, out_data, ovf
  );
endinterface

// File: rtl/ar_lane_collect4_acc.sv
// ar_lane_acc: one lane's MSB-first shift register, bit counter, holding register and sticky overflow
// cap/bit_in: capture strobe and bit; pop: hold consumed this cycle; hold_v/hold_data/ovf: lane state
module ar_lane_acc
  import ar_lane_collect4_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic              bit_in,
  input  logic              pop,
  output logic              hold_v,
  output logic [WORD_W-1:0] hold_data,
  output logic              ovf
);
  localparam int CW = cnt_w(WORD_W);
  logic [WORD_W-1:0] sr_q, sr_d, hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hold_v_q, hold_v_d, ovf_q, ovf_d;
  logic done, keep;
  always_comb begin
    done = cap && (cnt_q == CW'(WORD_W - 1));
    // a pop in the same cycle frees the slot, so the new word lands without overflow
    keep = hold_v_q & ~pop;
    sr_d = cap ? {sr_q[WORD_W-2:0], bit_in} : sr_q;
    cnt_d = cap ? (done ? '0 : cnt_q + 1'b1) : cnt_q;
    hold_d = (done && !keep) ? sr_d : hold_q;
    hold_v_d = keep | done;
    ovf_d = ovf_q | (done & keep);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
      cnt_q <= '0;
      hold_q <= '0;
      hold_v_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      hold_v_q <= hold_v_d;
      ovf_q <= ovf_d;
    end
  end
  assign hold_v = hold_v_q;
  assign hold_data = hold_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/ar_lane_collect4.sv
// ar_lane_collect4: assembles demux lane bits into per-lane words and hands them out round-robin
// clk/rst: clock and synchronous active-high reset; bus: ar_lane_collect4_if slave port
module ar_lane_collect4
  import ar_lane_collect4_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input logic clk,
  input logic rst,
  ar_lane_collect4_if.slave bus
);
  logic [LANES-1:0] cap, pop, hold_v, lane_ovf;
  logic [WORD_W-1:0] hold_data [LANES];
  logic bit_in, vld, hs;
  lane_t ptr_q, ptr_d, gnt, idx;
  always_comb begin
    bit_in = bus.in_y[bus.in_sel];
    cap = bus.in_valid ? LANES'(1) << bus.in_sel : '0;
    vld = |hold_v;
    gnt = ptr_q;
    idx = ptr_q;
    // scanning from the farthest offset back toward ptr leaves the nearest pending lane as grant
    for (int i = LANES - 1; i >= 0; i--) begin
      idx = ptr_q + lane_t'(i);
      if (hold_v[idx]) gnt = idx;
    end
    hs = vld & bus.out_ready;
    pop = hs ? LANES'(1) << gnt : '0;
    ptr_d = hs ? lane_t'(gnt + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
  genvar l;
  for (l = 0; l < LANES; l++) begin : g_lane
    ar_lane_acc #(.WORD_W(WORD_W)) u_acc (
      .clk(clk),
      .rst(rst),
      .cap(cap[l]),
      .bit_in(bit_in),
      .pop(pop[l]),
      .hold_v(hold_v[l]),
      .hold_data(hold_data[l]),
      .ovf(lane_ovf[l])
    );
  end
  assign bus.out_valid = vld;
  assign bus.out_lane = gnt;
  assign bus.out_data = hold_data[gnt];
  assign bus.ovf = lane_ovf;
endmodule

// File: tb/tb_ar_lane_collect4.sv
// tb_ar_lane_collect4: directed bench with a word-level model checked every cycle plus literal expectations
module tb_ar_lane_collect4;
  import ar_lane_collect4_pkg::*;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ar_lane_collect4_if #(.WORD_W(W)) bus();
  ar_lane_collect4 #(.WORD_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  int m_acc [4];
  int m_cnt [4];
  int m_hd [4];
  bit m_hv [4];
  bit [3:0] m_ovf = '0;
  int m_ptr = 0;
  bit m_rst = 1'b1;
  bit run = 1'b0;
  int cg;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int m_grant();
    for (int k = 0; k < 4; k++)
      if (m_hv[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction
  task automatic model_step();
    int g, ln;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_acc[k] = 0; m_cnt[k] = 0; m_hd[k] = 0; m_hv[k] = 0;
      end
      m_ptr = 0; m_ovf = '0; m_rst = 1'b1;
      return;
    end
    m_rst = 1'b0;
    g = m_grant();
    if (g >= 0 && bus.out_ready) begin
      m_hv[g] = 0;
      m_ptr = (g + 1) % 4;
    end
    if (bus.in_valid) begin
      ln = int'(bus.in_sel);
      m_acc[ln] = (m_acc[ln] * 2 + int'(bus.in_y[ln])) % (1 << W);
      m_cnt[ln]++;
      if (m_cnt[ln] == W) begin
        m_cnt[ln] = 0;
        if (m_hv[ln]) m_ovf[ln] = 1'b1;
        else begin
          m_hd[ln] = m_acc[ln];
          m_hv[ln] = 1;
        end
      end
    end
  endtask
  task automatic cyc(input bit v, input int sel, input logic [3:0] y, input bit rdy, input bit r = 1'b0);
    @(negedge clk);
    rst = r;
    bus.in_valid = v;
    bus.in_sel = sel[1:0];
    bus.in_y = y;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
    model_step();
  endtask
  task automatic send(input int lane, input int word, input bit rdy_last, input bit rdy);
    logic [3:0] y;
    for (int i = W - 1; i >= 0; i--) begin
      y = 4'hF;
      y[lane] = word[i];
      cyc(1'b1, lane, y, (i == 0) ? rdy_last : rdy);
    end
  endtask
  task automatic lit(input string nm, input bit v, input int lane, input int data);
    chk({nm, "_valid"}, bus.out_valid, v);
    chk({nm, "_mvalid"}, m_grant() >= 0, v);
    if (v) begin
      chk({nm, "_lane"}, bus.out_lane, lane);
      chk({nm, "_data"}, bus.out_data, data);
      chk({nm, "_mdata"}, m_hd[lane], data);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (run) begin
      cg = m_grant();
      chk("cmp_valid", bus.out_valid, cg >= 0);
      chk("cmp_ovf", bus.ovf, m_ovf);
      if (cg >= 0) begin
        chk("cmp_lane", bus.out_lane, cg);
        chk("cmp_data", bus.out_data, m_hd[cg]);
      end else if (m_rst) begin
        chk("cmp_rst_lane", bus.out_lane, 0);
        chk("cmp_rst_data", bus.out_data, 0);
      end
    end
  end
  initial begin
    logic [3:0] y;
    int ln;
    bus.in_valid = 1'b0;
    bus.in_sel = '0;
    bus.in_y = '0;
    bus.out_ready = 1'b0;
    cyc(0, 0, 4'h0, 1, 1);
    run = 1'b1;
    cyc(0, 0, 4'h0, 1, 1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_data", bus.out_data, 0);
    // single-lane word
    cyc(0, 0, 4'hF, 1);
    send(0, 'hA5, 1, 1);
    lit("single", 1, 0, 'hA5);
    cyc(0, 0, 4'h0, 1);
    lit("single_gone", 0, 0, 0);
    // interleave lanes 1 and 2
    for (int i = 0; i < 16; i++) begin
      ln = (i % 2 == 0) ? 1 : 2;
      y = 4'hF;
      y[ln] = (ln == 1) ? (i < 8) : (i >= 8);
      cyc(1, ln, y, 1);
      if (i == 14) lit("inter1", 1, 1, 'hF0);
      if (i == 15) lit("inter2", 1, 2, 'h0F);
    end
    cyc(0, 0, 4'h0, 1);
    lit("inter_gone", 0, 0, 0);
    chk("inter_ovf", bus.ovf, 0);
    // round robin, twice
    cyc(0, 0, 4'h0, 0, 1);
    for (int l = 0; l < 4; l++) send(l, 'h10 + l, 0, 0);
    for (int l = 0; l < 4; l++) begin
      lit("rr1", 1, l, 'h10 + l);
      cyc(0, 0, 4'h0, 1);
    end
    lit("rr1_gone", 0, 0, 0);
    for (int l = 3; l >= 0; l--) send(l, 'h20 + l, 0, 0);
    for (int l = 0; l < 4; l++) begin
      lit("rr2", 1, l, 'h20 + l);
      cyc(0, 0, 4'h0, 1);
    end
    lit("rr2_gone", 0, 0, 0);
    // pop plus completion on lane 0
    send(0, 'h55, 0, 0);
    lit("pc_old", 1, 0, 'h55);
    send(0, 'h3C, 1, 0);
    lit("pc_new", 1, 0, 'h3C);
    chk("pc_ovf", bus.ovf, 0);
    cyc(0, 0, 4'h0, 1);
    lit("pc_gone", 0, 0, 0);
    // overflow on lane 3
    send(3, 'h11, 0, 0);
    send(3, 'h22, 0, 0);
    chk("ovf_flag", bus.ovf, 4'b1000);
    lit("ovf_held", 1, 3, 'h11);
    cyc(0, 0, 4'h0, 1);
    lit("ovf_gone", 0, 0, 0);
    chk("ovf_sticky", bus.ovf, 4'b1000);
    // mid-word reset
    for (int i = 0; i < 5; i++) cyc(1, 2, 4'hF, 0);
    cyc(0, 0, 4'h0, 0, 1);
    chk("mr_ovf", bus.ovf, 0);
    lit("mr_empty", 0, 0, 0);
    for (int i = W - 1; i >= 0; i--) begin
      y = 4'hF;
      y[2] = i[0] ^ i[1] ^ 1'b1;
      y[2] = (8'hC3 >> i) & 1;
      cyc(1, 2, y, 0);
      cyc(0, 2, 4'hF, 0);
    end
    lit("mr_word", 1, 2, 'hC3);
    cyc(0, 2, 4'hF, 1);
    lit("mr_gone", 0, 0, 0);
    cyc(0, 0, 4'h0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ar_lane_collect4.md
# ar_lane_collect4

Downstream stage of the 1:4 bit demultiplexer. Each cycle it samples the demux's 4-bit one-hot lane output together with the select that produced it. It assembles the bits steered to each lane into WORD_W-bit words, one independent accumulator per lane. Completed words are held per lane and handed out one at a time over a valid/ready port using a round-robin arbiter.

## Interface
- WORD_W, 8, bits per assembled word; legal range 2..16

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  demux output is meaningful this cycle (the demux enable, registered alongside)
- in_sel  input  2  lane select that was driven into the demux this cycle
- in_y  input  4  demux output vector
- out_valid  output  1  a completed word is presented
- out_ready  input  1  consumer accepts the presented word
- out_lane  output  2  lane index of presented word
- out_data  output  WORD_W  presented word
- ovf  output  4  sticky per-lane overflow flags

## Operation
- Sampled bit:
  - When in_valid=1, bit = in_y[in_sel] is captured into lane in_sel.
  - Other in_y bits are ignored, including illegal non-one-hot values.
  - in_valid=0 captures nothing.
- Per-lane accumulator:
  - Shift register sr[WORD_W-1:0] plus bit counter cnt[ceil(log2(WORD_W+1))-1:0].
  - MSB-first: sr <= {sr[WORD_W-2:0], bit}; cnt increments on each capture.
- Word completion:
  - Completion is the capture that makes cnt = WORD_W.
  - The full word is written to the lane's holding register, hold_v <= 1, and cnt <= 0.
- Overflow:
  - A completion while hold_v=1 and that lane's hold is not popped this same cycle drops the new word.
  - The held word is kept, ovf[lane] <= 1 (sticky until rst), and cnt still returns to 0.
- Same-cycle pop and completion on the same lane: the pop wins the old word, the new word is stored, hold_v stays 1, and no overflow is flagged.
- Arbiter:
  - Round-robin pointer ptr[1:0], reset 0.
  - Grant = first lane with hold_v=1 scanning ptr, ptr+1, ... mod 4.
  - On handshake (out_valid & out_ready): clear hold_v of the granted lane, ptr <= granted+1 mod 4.
  - No handshake: ptr unchanged.
- Output port:
  - out_valid = |hold_v. out_lane and out_data reflect the grant combinationally from registers.
  - out_data and out_lane are don't-care when out_valid=0.
  - While out_valid=1 and out_ready=0, the presented word may change only if a higher-priority lane's hold becomes valid. The presented lane's hold is never lost.
- Reset values:
  - out_valid=0, out_lane=0, out_data=0, ovf=4'b0000.
  - All cnt=0, sr=0, hold_v=0, ptr=0.
- Reset mid-word discards all partial bits and held words.

## Timing
- Capture: registered on the rising edge where in_valid=1.
- Latency: out_valid rises on the cycle after the edge that captured the WORD_W-th bit of a lane, when no other hold is pending.
- Throughput: one word out per cycle maximum; one bit in per cycle.
- out_valid, out_lane, out_data: from flops through the 4-way priority mux only; no combinational path from in_* to out_*.
- out_ready only affects the next state (hold_v clear, ptr advance).

## Structure
- Shared package: lane count 4, select width 2, WORD_W default, and the count-width function.
- Sub-module ar_lane_acc: one lane's shift register, counter, holding register, overflow flag and pop input; instantiated 4 times.
- Top level: bit extract, lane decode, round-robin arbiter and output mux.

## Test plan
- Single-lane word:
  - rst then in_sel=0, in_valid=1, bits 1,0,1,0,0,1,0,1 on in_y[0] over 8 cycles, out_ready=1.
  - Expect out_valid on cycle 9 with out_lane=0, out_data=8'hA5, for one cycle.
- Interleave:
  - Alternate sel 1/2 for 16 cycles; lane 1 bits give 8'hF0, lane 2 bits give 8'h0F.
  - Expect both words, lane 1 first, each intact; ovf=0.
- Round robin:
  - Fill all four holds with out_ready=0, then out_ready=1.
  - Expect lanes 0,1,2,3 on 4 consecutive cycles; refill, and the next order starts at ptr=0 again.
- Overflow:
  - Lane 3 holds 8'h11 with out_ready=0, then complete 8'h22 on lane 3.
  - Expect ovf=4'b1000; after ready, out_data=8'h11 and hold empties.
- Pop plus complete:
  - Lane 0 hold valid and granted, out_ready=1 in the same cycle as a lane 0 completion of 8'h3C.
  - Expect no ovf; next word presented is 8'h3C.
- Mid-word reset:
  - Capture 5 bits on lane 2, assert rst one cycle, then send 8 new bits 8'hC3.
  - Expect exactly one word, 8'hC3; in_valid=0 cycles interleaved cause no capture.
